// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache with per-set round-robin replacement,
// fence.i flush and hit/miss counters. One outstanding 128-bit block fill at a time.
module icache_sa #(
  parameter int SET_BITS = 2,
  parameter int WAYS     = 2
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  input  logic         proc_flush,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);
  // state    | meaning
  // IDLE     | lookup / flush, hits served with zero added latency
  // READ_MEM | block fill outstanding, victim way already chosen
  localparam int SETS     = 1 << SET_BITS;
  localparam int TAG_W    = 28 - SET_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, READ_MEM} state_t;

  state_t                    state;
  logic                      mem_ready_q;
  logic [SETS-1:0][WAYS-1:0] valid;
  logic [TAG_W-1:0]          tag_mem  [SETS][WAYS];
  logic [127:0]              data_mem [SETS][WAYS];
  logic [WAY_BITS-1:0]       rr_ptr   [SETS];
  logic [WAY_BITS-1:0]       victim;
  logic                      victim_rr;

  logic [TAG_W-1:0]    addr_tag;
  logic [SET_BITS-1:0] addr_set;
  logic                hit;
  logic [127:0]        hit_block;
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [31:0]         hit_word;
  logic [31:0]         fill_word;
  logic                unused;

  assign addr_tag  = proc_addr[29:2+SET_BITS];
  assign addr_set  = proc_addr[1+SET_BITS:2];
  assign hit_word  = hit_block[{proc_addr[1:0], 5'd0} +: 32];
  assign fill_word = mem_rdata[{proc_addr[1:0], 5'd0} +: 32];
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  assign unused    = ^{proc_write, proc_wdata};

  always_comb begin
    hit       = 1'b0;
    hit_block = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[addr_set][w] && tag_mem[addr_set][w] == addr_tag) begin
        hit       = 1'b1;
        hit_block = data_mem[addr_set][w];
      end
    end
    // Scan downwards so the lowest-numbered invalid way wins.
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[addr_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    proc_rdata = '0;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (proc_flush) begin
          proc_stall = 1'b1;
        end else if (proc_read) begin
          if (hit) begin
            proc_rdata = hit_word;
          end else begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = proc_addr[29:2];
          end
        end
      end
      READ_MEM: begin
        if (mem_ready_q) begin
          proc_rdata = fill_word;
        end else begin
          proc_stall = 1'b1;
          mem_read   = 1'b1;
          mem_addr   = proc_addr[29:2];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state       <= IDLE;
      mem_ready_q <= 1'b0;
      valid       <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      victim      <= '0;
      victim_rr   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
        end
      end
    end else begin
      mem_ready_q <= mem_ready;
      case (state)
        IDLE: begin
          if (proc_flush) begin
            valid <= '0;
          end else if (proc_read) begin
            if (hit) begin
              hit_cnt <= hit_cnt + 32'd1;
            end else begin
              miss_cnt  <= miss_cnt + 32'd1;
              victim    <= inv_found ? inv_way : rr_ptr[addr_set];
              victim_rr <= !inv_found;
              state     <= READ_MEM;
            end
          end
        end
        READ_MEM: begin
          if (mem_ready_q) begin
            for (int w = 0; w < WAYS; w++) begin
              if (victim == WAY_BITS'(w)) begin
                valid[addr_set][w]    <= 1'b1;
                tag_mem[addr_set][w]  <= addr_tag;
                data_mem[addr_set][w] <= mem_rdata;
              end
            end
            if (victim_rr) begin
              rr_ptr[addr_set] <= (rr_ptr[addr_set] == WAY_BITS'(WAYS - 1)) ?
                                  '0 : rr_ptr[addr_set] + 1'b1;
            end
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: vector table, hand-written corner sequences and random fetches
// checked against an array-based cache model; a second instance covers the 1-way build.
module tb_icache_sa;
  logic         clk = 1'b0;
  logic         proc_reset = 1'b0, proc_read = 1'b0, proc_write = 1'b0, proc_flush = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  logic [31:0]  a_rdata, b_rdata, a_hit, b_hit, a_miss, b_miss;
  logic         a_stall, b_stall, a_mrd, b_mrd, a_mwr, b_mwr;
  logic [27:0]  a_maddr, b_maddr;
  logic [127:0] a_wdata, b_wdata;

  icache_sa #(.SET_BITS(2), .WAYS(2)) a_dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_flush(proc_flush),
    .proc_rdata(a_rdata), .proc_stall(a_stall), .mem_read(a_mrd), .mem_write(a_mwr),
    .mem_addr(a_maddr), .mem_rdata(mem_rdata), .mem_wdata(a_wdata), .mem_ready(mem_ready),
    .hit_cnt(a_hit), .miss_cnt(a_miss));

  icache_sa #(.SET_BITS(2), .WAYS(1)) b_dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_flush(proc_flush),
    .proc_rdata(b_rdata), .proc_stall(b_stall), .mem_read(b_mrd), .mem_write(b_mwr),
    .mem_addr(b_maddr), .mem_rdata(mem_rdata), .mem_wdata(b_wdata), .mem_ready(mem_ready),
    .hit_cnt(b_hit), .miss_cnt(b_miss));

  always #5 clk = ~clk;

  bit sel = 1'b0;
  wire [31:0] rdata    = sel ? b_rdata : a_rdata;
  wire        stall    = sel ? b_stall : a_stall;
  wire        mrd      = sel ? b_mrd   : a_mrd;
  wire        mwr      = sel ? b_mwr   : a_mwr;
  wire [27:0] maddr    = sel ? b_maddr : a_maddr;
  wire [31:0] hit_cnt  = sel ? b_hit   : a_hit;
  wire [31:0] miss_cnt = sel ? b_miss  : a_miss;

  int n_pass = 0, n_total = 0;

  // Reference model: 4 sets, up to 4 ways, replacement rules applied directly.
  int          mw = 2;
  bit          mv [4][4];
  logic [25:0] mt [4][4];
  int          mrr [4];
  logic [31:0] m_hits, m_misses;

  function automatic logic [127:0] blk_data(input logic [27:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'hAAAA0000 ^ {2'b00, b, 2'(k)};
    return r;
  endfunction

  function automatic bit m_hit(input logic [29:0] a);
    for (int w = 0; w < mw; w++)
      if (mv[a[3:2]][w] && mt[a[3:2]][w] == a[29:4]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_fill(input logic [29:0] a);
    int s, v;
    s = int'(a[3:2]);
    v = -1;
    for (int w = mw - 1; w >= 0; w--) if (!mv[s][w]) v = w;
    if (v < 0) begin
      v = mrr[s];
      mrr[s] = (mrr[s] + 1) % mw;
    end
    mv[s][v] = 1'b1;
    mt[s][v] = a[29:4];
  endtask

  task automatic m_reset();
    for (int s = 0; s < 4; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < 4; w++) mv[s][w] = 1'b0;
    end
    m_hits = '0;
    m_misses = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Entered and left just after a falling edge.
  task automatic do_reset();
    proc_reset = 1'b1; proc_read = 1'b0; proc_flush = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    m_reset();
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_read", {31'd0, mrd}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", {4'd0, maddr}, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [29:0] a, input bit exp_hit, input int lat);
    logic [127:0] blk;
    logic [31:0]  w;
    blk = blk_data(a[29:2]);
    w = blk[{a[1:0], 5'd0} +: 32];
    proc_read = 1'b1;
    proc_addr = a;
    #2;
    chk("lookup_stall", {31'd0, stall}, exp_hit ? 32'd0 : 32'd1);
    chk("mem_write_tied", {31'd0, mwr}, 32'd0);
    if (exp_hit) begin
      chk("hit_rdata", rdata, w);
      m_hits = m_hits + 1;
      @(negedge clk);
    end else begin
      chk("miss_mem_read", {31'd0, mrd}, 32'd1);
      chk("miss_mem_addr", {4'd0, maddr}, {4'd0, a[29:2]});
      m_misses = m_misses + 1;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        #2;
        chk("wait_stall", {31'd0, stall}, 32'd1);
        chk("wait_mem_read", {31'd0, mrd}, 32'd1);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = blk;
      #2;
      chk("ready_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      mem_ready = 1'b0;
      #2;
      chk("fill_stall", {31'd0, stall}, 32'd0);
      chk("fill_rdata", rdata, w);
      chk("fill_mem_read", {31'd0, mrd}, 32'd0);
      m_fill(a);
      @(negedge clk);
    end
    proc_read = 1'b0;
  endtask

  task automatic do_flush();
    proc_flush = 1'b1;
    proc_read = 1'b1;
    #2;
    chk("flush_stall", {31'd0, stall}, 32'd1);
    chk("flush_mem_read", {31'd0, mrd}, 32'd0);
    @(negedge clk);
    proc_flush = 1'b0;
    proc_read = 1'b0;
    for (int s = 0; s < 4; s++) for (int w = 0; w < 4; w++) mv[s][w] = 1'b0;
    #2;
    chk("post_flush_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst;
    logic [29:0] addr;
    bit          exp_hit;
    int          lat;
  } vec_t;
  vec_t tv [11];

  initial begin
    logic [29:0] ra;
    tv[0]  = '{1'b1, 30'h04, 1'b0, 2};
    tv[1]  = '{1'b0, 30'h04, 1'b1, 0};
    tv[2]  = '{1'b1, 30'h00, 1'b0, 1};
    tv[3]  = '{1'b0, 30'h10, 1'b0, 0};
    tv[4]  = '{1'b0, 30'h20, 1'b0, 3};
    tv[5]  = '{1'b0, 30'h10, 1'b1, 0};
    tv[6]  = '{1'b0, 30'h00, 1'b0, 1};
    tv[7]  = '{1'b0, 30'h20, 1'b1, 0};
    tv[8]  = '{1'b0, 30'h00, 1'b1, 0};
    tv[9]  = '{1'b0, 30'h10, 1'b0, 0};
    tv[10] = '{1'b0, 30'h03, 1'b1, 0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (tv[i].rst) begin
        if (i > 0) begin
          chk("tbl_hit_cnt", hit_cnt, m_hits);
          chk("tbl_miss_cnt", miss_cnt, m_misses);
        end
        do_reset();
      end
      do_read(tv[i].addr, tv[i].exp_hit, tv[i].lat);
      if (i == 1) begin
        chk("t1_hit_cnt", hit_cnt, 32'd1);
        chk("t1_miss_cnt", miss_cnt, 32'd1);
      end
    end
    chk("tbl_end_hit_cnt", hit_cnt, m_hits);
    chk("tbl_end_miss_cnt", miss_cnt, m_misses);

    // Flush invalidates both resident lines.
    do_reset();
    do_read(30'h40, 1'b0, 1);
    do_read(30'h44, 1'b0, 1);
    do_flush();
    do_read(30'h40, 1'b0, 0);
    do_read(30'h44, 1'b0, 0);
    chk("flush_miss_cnt", miss_cnt, 32'd4);
    chk("flush_hit_cnt", hit_cnt, 32'd0);

    // Reset while a fill is outstanding, then a stale ready reaches IDLE.
    do_reset();
    proc_read = 1'b1;
    proc_addr = 30'h50;
    #2;
    chk("abort_miss_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0;
    proc_read = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = blk_data(28'h14);
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    chk("stale_stall", {31'd0, stall}, 32'd0);
    chk("stale_mem_read", {31'd0, mrd}, 32'd0);
    chk("stale_rdata", rdata, 32'd0);
    chk("abort_hit_cnt", hit_cnt, 32'd0);
    chk("abort_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    m_reset();
    do_read(30'h50, 1'b0, 0);

    // Random fetches with occasional flushes.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 11) == 0) do_flush();
      else begin
        ra = 30'($urandom_range(0, 127));
        do_read(ra, m_hit(ra), int'($urandom_range(0, 3)));
      end
    end
    chk("rand_hit_cnt", hit_cnt, m_hits);
    chk("rand_miss_cnt", miss_cnt, m_misses);

    // Hit counter wrap.
    do_read(30'h7C, m_hit(30'h7C), 1);
    force a_dut.hit_cnt = 32'hFFFFFFFF;
    #1;
    release a_dut.hit_cnt;
    @(negedge clk);
    do_read(30'h7D, 1'b1, 0);
    chk("wrap_hit_cnt", hit_cnt, 32'd0);

    // Direct-mapped build over a 64-word loop plus a partial replay.
    sel = 1'b1;
    mw = 1;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      ra = (i < 64) ? 30'(i) : 30'(i - 32);
      do_read(ra, m_hit(ra), i % 3);
    end
    chk("dm_hit_cnt", hit_cnt, m_hits);
    chk("dm_miss_cnt", miss_cnt, m_misses);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
